instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Fetch-stage initiator for the combinational, read-only instruction memory (16-bit word address in, 32-bit instruction out).
- Owns the program counter, drives the memory address every cycle and registers the returned word into the IF/ID pipeline register.
- Handles stall and redirect from later stages.
- Sits between the PC/branch logic of the processor core and the instruction memory; feeds the decode stage.

Parameters:
- ADDR_W, 16, instruction memory word-address width (PC width)
- INSTR_W, 32, instruction word width
- RESET_PC, 0, PC value loaded on reset

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  leave IDLE and begin fetching
- imem_addr  out  ADDR_W  word address to instruction memory; equals pc
- imem_instr  in  INSTR_W  instruction word returned combinationally for imem_addr
- stall  in  1  decode is not accepting; hold PC and IF/ID register
- redirect_valid  in  1  execute-stage taken branch/jump; flush and load redirect_pc
- redirect_pc  in  ADDR_W  redirect target word address
- halt_req  in  1  decode requests processor halt
- if_valid  out  1  if_instr/if_pc hold a live instruction
- if_instr  out  INSTR_W  registered instruction
- if_pc  out  ADDR_W  address if_instr was fetched from
- if_predicted  out  1  if_instr is a jump already followed by fetch (see Optional Feature)
- halted  out  1  unit is in HALT

Behaviour:
- Reset (async, any state, including mid-fetch): pc=RESET_PC, state=IDLE, if_valid=0, if_instr=0, if_pc=0, if_predicted=0, halted=0.
- imem_addr = pc, combinational. Memory latency is 0, so the fetched word is registered on the same edge.
- States are IDLE, RUN and HALT.
- IDLE: pc held, if_valid=0. On start=1, go to RUN; the first fetch happens on the next edge.
- RUN, per edge, highest priority first:
  1. halt_req=1: state goes to HALT, if_valid goes to 0, pc held.
  2. redirect_valid=1: pc<=redirect_pc and if_valid<=0 (flushes the wrong-path word). Redirect wins over stall.
  3. stall=1: pc, if_valid, if_instr, if_pc and if_predicted all held.
  4. Otherwise: if_instr<=imem_instr, if_pc<=pc, if_valid<=1, pc<=pc+1.
- PC arithmetic is modulo 2^ADDR_W: 16'hFFFF+1 wraps to 16'h0000 with no flag.
- HALT: pc frozen, if_valid=0, halted=1. start, stall and redirect are ignored. Only rst exits HALT.
- redirect_valid and halt_req are ignored in IDLE.
- Throughput is one instruction per cycle when there is no stall or redirect. A redirect costs exactly one bubble cycle.

Optional Feature:
- Macro: FETCH_JUMP_PREDECODE_EN.
- With the macro defined, in RUN case 4, if imem_instr[31:26]==6'b010100 (unconditional jump), then:
  - pc<=imem_instr[ADDR_W-1:0] instead of pc+1;
  - the word is still emitted with if_predicted<=1;
  - decode must not issue redirect_valid for a word with if_predicted=1.
- If the jump target equals the current pc (jump-to-self, the program-end idiom), the word is emitted and the state goes to HALT on the same edge.
- Without the macro: no predecode, if_predicted is tied to 0, and jumps resolve only through redirect_valid.

Decomposition:
- Shared package (cpu_pkg) holds:
  - ADDR_W and INSTR_W constants;
  - the opcode field slice constants OPC_HI=31 and OPC_LO=26;
  - the opcode constant OPC_JUMP=6'b010100;
  - the fetch state enum {IDLE, RUN, HALT}.
- One natural sub-module: jump_predecoder. It is combinational: instr in; is_jump and target out. It is only instantiated under FETCH_JUMP_PREDECODE_EN.

Test Plan:
- Sequential fetch: reset, pulse start, memory returns word k at address k, no stall. Expect if_pc=0,1,2,3 on consecutive cycles with if_valid=1 and if_instr matching each address.
- Stall: assert stall for 3 cycles while if_pc=5. Expect if_pc=5 and if_instr unchanged, imem_addr=6 held; fetch resumes with if_pc=6.
- Redirect priority: at pc=8, assert redirect_valid=1 with redirect_pc=2 and stall=1 together. Expect one cycle of if_valid=0, then if_pc=2 valid.
- Wrap: RESET_PC=16'hFFFE. Expect if_pc sequence FFFE, FFFF, 0000.
- Halt and async reset: halt_req at pc=4. Expect halted=1, if_valid=0, and pc frozen for 10 cycles despite start/redirect. Assert rst mid-cycle: expect immediate pc=RESET_PC and state=IDLE.
- Predecode (macro on): word 0x5000_0006 at addr 3. Expect if_predicted=1 for if_pc=3 and next if_pc=6. Then word 0x5000_0014 at addr 20: expect it emitted, then halted=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants, opcode fields and fetch state type
package cpu_pkg;
  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 32;
  localparam int OPC_HI  = 31;
  localparam int OPC_LO  = 26;
  localparam logic [5:0] OPC_JUMP = 6'b010100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;
endpackage

// File: rtl/instr_fetch_unit_jump_predecoder.sv
// rtl/instr_fetch_unit_jump_predecoder.sv - combinational detection of unconditional jumps
module jump_predecoder #(
  parameter int ADDR_W  = cpu_pkg::ADDR_W,
  parameter int INSTR_W = cpu_pkg::INSTR_W
) (
  input  logic [INSTR_W-1:0] instr_i,
  output logic               is_jump_o,
  output logic [ADDR_W-1:0]  target_o
);
  import cpu_pkg::*;

  // Bits between the target field and the opcode carry nothing for a jump.
  logic unused_mid_bits;

  assign is_jump_o       = (instr_i[OPC_HI:OPC_LO] == OPC_JUMP);
  assign target_o        = instr_i[ADDR_W-1:0];
  assign unused_mid_bits = ^instr_i[OPC_LO-1:ADDR_W];
endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC owner and IF/ID register for a zero-latency instruction memory
// Build option FETCH_JUMP_PREDECODE_EN follows unconditional jumps at fetch time.
module instr_fetch_unit #(
  parameter int                         ADDR_W   = cpu_pkg::ADDR_W,
  parameter int                         INSTR_W  = cpu_pkg::INSTR_W,
  parameter logic [cpu_pkg::ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               halt_req,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic               if_predicted,
  output logic               halted
);
  import cpu_pkg::*;

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  if_pc_q, if_pc_d;
  logic [INSTR_W-1:0] if_instr_q, if_instr_d;
  logic               if_valid_q, if_valid_d;
  logic               if_pred_q, if_pred_d;

  logic               jump_hit;
  logic               jump_self;
  logic [ADDR_W-1:0]  fetch_next_pc;

`ifdef FETCH_JUMP_PREDECODE_EN
  logic [ADDR_W-1:0]  jump_target;

  jump_predecoder #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_jump_predecoder (
    .instr_i   (imem_instr),
    .is_jump_o (jump_hit),
    .target_o  (jump_target)
  );

  assign jump_self     = jump_hit && (jump_target == pc_q);
  assign fetch_next_pc = jump_hit ? jump_target : pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
`else
  assign jump_hit      = 1'b0;
  assign jump_self     = 1'b0;
  assign fetch_next_pc = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      if_pc_q    <= '0;
      if_instr_q <= '0;
      if_valid_q <= 1'b0;
      if_pred_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      if_valid_q <= if_valid_d;
      if_pred_q  <= if_pred_d;
    end
  end

  // A jump-to-self only halts when the word is actually consumed this edge.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN: begin
        if (halt_req) state_d = HALT;
        else if (!redirect_valid && !stall && jump_self) state_d = HALT;
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pc_d       = pc_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    if_valid_d = if_valid_q;
    if_pred_d  = if_pred_q;
    case (state_q)
      RUN: begin
        if (halt_req || redirect_valid) begin
          if_valid_d = 1'b0;
          if_pred_d  = 1'b0;
          if (!halt_req) pc_d = redirect_pc;
        end else if (!stall) begin
          if_instr_d = imem_instr;
          if_pc_d    = pc_q;
          if_valid_d = 1'b1;
          if_pred_d  = jump_hit;
          pc_d       = fetch_next_pc;
        end
      end
      default: begin
        if_valid_d = 1'b0;
        if_pred_d  = 1'b0;
      end
    endcase
  end

  assign imem_addr    = pc_q;
  assign if_valid     = if_valid_q;
  assign if_instr     = if_instr_q;
  assign if_pc        = if_pc_q;
  assign if_predicted = if_pred_q;
  assign halted       = (state_q == HALT);
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed vector bench for instr_fetch_unit
module tb_instr_fetch_unit;
  logic        clk = 1'b0;
  logic        rst, start, stall, redirect_valid, halt_req, special_en;
  logic [15:0] redirect_pc;
  logic [15:0] imem_addr, imem_addr_w, if_pc, if_pc_w;
  logic [31:0] imem_instr, imem_instr_w, if_instr, if_instr_w;
  logic        if_valid, if_valid_w, if_predicted, if_predicted_w, halted, halted_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [15:0] a, input logic sp);
    if (sp && a == 16'd3)  return 32'h5000_0006;
    if (sp && a == 16'd20) return 32'h5000_0014;
    return {16'hC0DE, a};
  endfunction

  always_comb imem_instr   = mem_word(imem_addr, special_en);
  always_comb imem_instr_w = mem_word(imem_addr_w, 1'b0);

  instr_fetch_unit #(.ADDR_W(16), .INSTR_W(32), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .start(start), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt_req(halt_req), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .if_predicted(if_predicted), .halted(halted)
  );

  instr_fetch_unit #(.ADDR_W(16), .INSTR_W(32), .RESET_PC(16'hFFFE)) dut_w (
    .clk(clk), .rst(rst), .start(start), .imem_addr(imem_addr_w), .imem_instr(imem_instr_w),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt_req(halt_req), .if_valid(if_valid_w), .if_instr(if_instr_w), .if_pc(if_pc_w),
    .if_predicted(if_predicted_w), .halted(halted_w)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic sl, input logic rv, input logic hr,
                       input logic [15:0] rp);
    start = st; stall = sl; redirect_valid = rv; halt_req = hr; redirect_pc = rp;
  endtask

  typedef struct {
    logic        st, sl, rv, hr;
    logic [15:0] rp;
    logic        ev;
    logic [15:0] epc;
    logic [15:0] eaddr;
    logic        eh;
    logic        cw;
    logic [15:0] ewpc;
  } vec_t;

  vec_t tbl[26];

  initial begin
    //          st sl rv hr rp      ev epc    eaddr  eh cw ewpc
    tbl[0]  = '{1, 0, 0, 0, 16'd0,  0, 16'd0, 16'd0, 0, 0, 16'h0000};
    tbl[1]  = '{0, 0, 0, 0, 16'd0,  1, 16'd0, 16'd1, 0, 1, 16'hFFFE};
    tbl[2]  = '{0, 0, 0, 0, 16'd0,  1, 16'd1, 16'd2, 0, 1, 16'hFFFF};
    tbl[3]  = '{0, 0, 0, 0, 16'd0,  1, 16'd2, 16'd3, 0, 1, 16'h0000};
    tbl[4]  = '{0, 0, 0, 0, 16'd0,  1, 16'd3, 16'd4, 0, 0, 16'h0000};
    tbl[5]  = '{0, 0, 0, 0, 16'd0,  1, 16'd4, 16'd5, 0, 0, 16'h0000};
    tbl[6]  = '{0, 0, 0, 0, 16'd0,  1, 16'd5, 16'd6, 0, 0, 16'h0000};
    tbl[7]  = '{0, 1, 0, 0, 16'd0,  1, 16'd5, 16'd6, 0, 0, 16'h0000};
    tbl[8]  = '{0, 1, 0, 0, 16'd0,  1, 16'd5, 16'd6, 0, 0, 16'h0000};
    tbl[9]  = '{0, 1, 0, 0, 16'd0,  1, 16'd5, 16'd6, 0, 0, 16'h0000};
    tbl[10] = '{0, 0, 0, 0, 16'd0,  1, 16'd6, 16'd7, 0, 0, 16'h0000};
    tbl[11] = '{0, 0, 0, 0, 16'd0,  1, 16'd7, 16'd8, 0, 0, 16'h0000};
    tbl[12] = '{0, 1, 1, 0, 16'd2,  0, 16'd0, 16'd2, 0, 0, 16'h0000};
    tbl[13] = '{0, 0, 0, 0, 16'd0,  1, 16'd2, 16'd3, 0, 0, 16'h0000};
    tbl[14] = '{0, 0, 0, 0, 16'd0,  1, 16'd3, 16'd4, 0, 0, 16'h0000};
    tbl[15] = '{0, 0, 0, 1, 16'd0,  0, 16'd0, 16'd4, 1, 0, 16'h0000};
    for (int i = 16; i < 26; i++)
      tbl[i] = '{1, logic'(i % 2), 1, 0, 16'd9, 0, 16'd0, 16'd4, 1, 0, 16'h0000};

    special_en = 1'b0;
    rst = 1'b1;
    drive(0, 0, 0, 0, 16'd0);
    #12;
    check("reset if_valid", {31'd0, if_valid}, 32'd0);
    check("reset if_pc", {16'd0, if_pc}, 32'd0);
    check("reset if_instr", if_instr, 32'd0);
    check("reset halted", {31'd0, halted}, 32'd0);
    check("reset imem_addr", {16'd0, imem_addr}, 32'd0);
    check("reset wrap imem_addr", {16'd0, imem_addr_w}, 32'h0000_FFFE);
    check("reset wrap if_pc", {16'd0, if_pc_w}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 26; i++) begin
      drive(tbl[i].st, tbl[i].sl, tbl[i].rv, tbl[i].hr, tbl[i].rp);
      @(posedge clk);
      #1;
      check($sformatf("row%0d if_valid", i), {31'd0, if_valid}, {31'd0, tbl[i].ev});
      check($sformatf("row%0d imem_addr", i), {16'd0, imem_addr}, {16'd0, tbl[i].eaddr});
      check($sformatf("row%0d halted", i), {31'd0, halted}, {31'd0, tbl[i].eh});
      check($sformatf("row%0d if_predicted", i), {31'd0, if_predicted}, 32'd0);
      if (tbl[i].ev) begin
        check($sformatf("row%0d if_pc", i), {16'd0, if_pc}, {16'd0, tbl[i].epc});
        check($sformatf("row%0d if_instr", i), if_instr, mem_word(tbl[i].epc, 1'b0));
      end
      if (tbl[i].cw) begin
        check($sformatf("row%0d wrap if_valid", i), {31'd0, if_valid_w}, 32'd1);
        check($sformatf("row%0d wrap if_pc", i), {16'd0, if_pc_w}, {16'd0, tbl[i].ewpc});
        check($sformatf("row%0d wrap if_instr", i), if_instr_w, mem_word(tbl[i].ewpc, 1'b0));
      end
    end

    // Asynchronous reset in the middle of a cycle while halted.
    #2;
    rst = 1'b1;
    #1;
    check("async rst imem_addr", {16'd0, imem_addr}, 32'd0);
    check("async rst wrap imem_addr", {16'd0, imem_addr_w}, 32'h0000_FFFE);
    check("async rst halted", {31'd0, halted}, 32'd0);
    check("async rst if_valid", {31'd0, if_valid}, 32'd0);
    check("async rst if_pc", {16'd0, if_pc}, 32'd0);
    drive(0, 0, 1, 1, 16'd9);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("idle%0d imem_addr", i), {16'd0, imem_addr}, 32'd0);
      check($sformatf("idle%0d if_valid", i), {31'd0, if_valid}, 32'd0);
      check($sformatf("idle%0d halted", i), {31'd0, halted}, 32'd0);
    end

    // Jump words present in memory from here on.
    special_en = 1'b1;
    drive(1, 0, 0, 0, 16'd0);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 16'd0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("pd fetch%0d if_pc", k), {16'd0, if_pc}, k);
      check($sformatf("pd fetch%0d if_instr", k), if_instr, mem_word(16'(k), 1'b1));
    end
`ifdef FETCH_JUMP_PREDECODE_EN
    check("pd jump if_predicted", {31'd0, if_predicted}, 32'd1);
    check("pd jump imem_addr", {16'd0, imem_addr}, 32'd6);
    @(posedge clk);
    #1;
    check("pd target if_pc", {16'd0, if_pc}, 32'd6);
    check("pd target if_predicted", {31'd0, if_predicted}, 32'd0);
    drive(0, 0, 1, 0, 16'd20);
    @(posedge clk);
    #1;
    check("pd redirect if_valid", {31'd0, if_valid}, 32'd0);
    check("pd redirect imem_addr", {16'd0, imem_addr}, 32'd20);
    drive(0, 0, 0, 0, 16'd0);
    @(posedge clk);
    #1;
    check("pd self if_valid", {31'd0, if_valid}, 32'd1);
    check("pd self if_pc", {16'd0, if_pc}, 32'd20);
    check("pd self if_instr", if_instr, 32'h5000_0014);
    check("pd self if_predicted", {31'd0, if_predicted}, 32'd1);
    check("pd self halted", {31'd0, halted}, 32'd1);
    @(posedge clk);
    #1;
    check("pd after if_valid", {31'd0, if_valid}, 32'd0);
    check("pd after halted", {31'd0, halted}, 32'd1);
    check("pd after imem_addr", {16'd0, imem_addr}, 32'd20);
`else
    check("nopd jump if_predicted", {31'd0, if_predicted}, 32'd0);
    check("nopd jump imem_addr", {16'd0, imem_addr}, 32'd4);
    @(posedge clk);
    #1;
    check("nopd next if_pc", {16'd0, if_pc}, 32'd4);
    drive(0, 0, 1, 0, 16'd20);
    @(posedge clk);
    #1;
    check("nopd redirect if_valid", {31'd0, if_valid}, 32'd0);
    check("nopd redirect imem_addr", {16'd0, imem_addr}, 32'd20);
    drive(0, 0, 0, 0, 16'd0);
    @(posedge clk);
    #1;
    check("nopd self if_pc", {16'd0, if_pc}, 32'd20);
    check("nopd self if_instr", if_instr, 32'h5000_0014);
    check("nopd self if_predicted", {31'd0, if_predicted}, 32'd0);
    check("nopd self halted", {31'd0, halted}, 32'd0);
    check("nopd self imem_addr", {16'd0, imem_addr}, 32'd21);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
